// File: rtl/playfield_scanner_pkg.sv
// Cell colour and scan-state types plus board geometry.
// Shared by the playfield scan path and the board controller.
package playfield_scanner_pkg;
  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    CYAN    = 3'd1,
    BLUE    = 3'd2,
    ORANGE  = 3'd3,
    YELLOW  = 3'd4,
    GREEN   = 3'd5,
    RED     = 3'd6,
    MAGENTA = 3'd7
  } block_color;

  typedef logic [1:0] scan_state_t;
  localparam scan_state_t IDLE  = 2'd0;
  localparam scan_state_t FETCH = 2'd1;
  localparam scan_state_t DONE  = 2'd2;

  localparam int PF_BOARD_COLS = 10;
  localparam int PF_BOARD_ROWS = 20;
  localparam int PF_CELL_LOG2  = 4;
  localparam int PF_ORIGIN_X   = 240;
  localparam int PF_ORIGIN_Y   = 80;
  localparam int PF_H_ACTIVE   = 640;
  localparam int PF_H_TOTAL    = 800;
  localparam int PF_V_TOTAL    = 525;
endpackage

// File: rtl/scan_row_buffer.sv
// Ping-pong row buffer: back half filled by the fetch, front half read by the pixel path.
// Combinational read; swap and writes take effect on the next edge; no backpressure.
module scan_row_buffer
  import playfield_scanner_pkg::*;
#(
  parameter int COLS = PF_BOARD_COLS
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_en,
  input  logic [3:0] i_wr_idx,
  input  logic [2:0] i_wr_dat,
  input  logic       i_swap,
  input  logic [3:0] i_rd_idx,
  output logic [2:0] o_rd_dat
);
  localparam logic [3:0] LP_COLS = 4'(COLS);

  block_color r_buf [2][COLS];
  logic       r_front_sel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_front_sel <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < COLS; c++) begin
          r_buf[b][c] <= EMPTY;
        end
      end
    end else begin
      if (i_wr_en && (i_wr_idx < LP_COLS)) begin
        r_buf[~r_front_sel][i_wr_idx] <= block_color'(i_wr_dat);
      end
      if (i_swap) begin
        r_front_sel <= ~r_front_sel;
      end
    end
  end

  // Indices past the board edge only occur outside the play area; return EMPTY there.
  assign o_rd_dat = (i_rd_idx < LP_COLS) ? r_buf[r_front_sel][i_rd_idx] : EMPTY;
endmodule

// File: rtl/playfield_scanner.sv
// Fetches one board row per cell-row during h-blank and maps each pixel to its cell colour.
// Pixel outputs lag DrawX/DrawY by one cycle; the read port holds rd_req/rd_row/rd_col until rd_ack.
module playfield_scanner
  import playfield_scanner_pkg::*;
#(
  parameter int BOARD_COLS = PF_BOARD_COLS,
  parameter int BOARD_ROWS = PF_BOARD_ROWS,
  parameter int CELL_LOG2  = PF_CELL_LOG2,
  parameter int ORIGIN_X   = PF_ORIGIN_X,
  parameter int ORIGIN_Y   = PF_ORIGIN_Y,
  parameter int H_ACTIVE   = PF_H_ACTIVE,
  parameter int H_TOTAL    = PF_H_TOTAL,
  parameter int V_TOTAL    = PF_V_TOTAL
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       rd_req,
  output logic [4:0] rd_row,
  output logic [3:0] rd_col,
  input  logic       rd_ack,
  input  logic [2:0] rd_data,
  output logic       play_area,
  output logic [2:0] block_type,
  output logic       underrun
);
  localparam logic [9:0] LP_X0       = 10'(ORIGIN_X);
  localparam logic [9:0] LP_X1       = 10'(ORIGIN_X + (BOARD_COLS << CELL_LOG2));
  localparam logic [9:0] LP_Y0       = 10'(ORIGIN_Y);
  localparam logic [9:0] LP_Y1       = 10'(ORIGIN_Y + (BOARD_ROWS << CELL_LOG2));
  localparam logic [9:0] LP_H_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0] LP_H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] LP_V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [3:0] LP_LAST_COL = 4'(BOARD_COLS - 1);

  scan_state_t r_state;
  logic        r_rd_req;
  logic [4:0]  r_rd_row;
  logic [3:0]  r_rd_col;
  logic        r_underrun;
  logic        r_play_area;
  block_color  r_block_type;

  logic [9:0]  w_next_y;
  logic [9:0]  w_ny_off;
  logic [9:0]  w_x_off;
  logic [4:0]  w_trig_row;
  logic [3:0]  w_cell_x;
  logic [2:0]  w_front_dat;
  logic        w_trig;
  logic        w_line_end;
  logic        w_in_area;
  logic        w_wr_en;
  logic        w_swap;

  // The fetch at the end of line N prepares the row shown on line N+1.
  assign w_next_y   = (DrawY == LP_V_LAST) ? 10'd0 : DrawY + 10'd1;
  assign w_ny_off   = w_next_y - LP_Y0;
  assign w_trig_row = 5'(w_ny_off >> CELL_LOG2);
  assign w_trig     = (DrawX == LP_H_ACTIVE) && (w_next_y >= LP_Y0) && (w_next_y < LP_Y1)
                      && (w_ny_off[CELL_LOG2-1:0] == '0);
  assign w_line_end = (DrawX == LP_H_LAST);

  assign w_wr_en = (r_state == FETCH) && rd_ack;
  assign w_swap  = (r_state == DONE) && w_line_end;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_rd_req   <= 1'b0;
      r_rd_row   <= 5'd0;
      r_rd_col   <= 4'd0;
      r_underrun <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_trig) begin
            r_state  <= FETCH;
            r_rd_req <= 1'b1;
            r_rd_row <= w_trig_row;
            r_rd_col <= 4'd0;
          end
        end
        FETCH: begin
          // Missing the swap point abandons the row; the front keeps the old one.
          if (w_line_end) begin
            r_underrun <= 1'b1;
            r_rd_req   <= 1'b0;
            r_state    <= IDLE;
          end else if (rd_ack) begin
            if (r_rd_col == LP_LAST_COL) begin
              r_rd_req <= 1'b0;
              r_state  <= DONE;
            end else begin
              r_rd_col <= r_rd_col + 4'd1;
            end
          end
        end
        DONE: begin
          if (w_line_end) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_in_area = (DrawX >= LP_X0) && (DrawX < LP_X1) && (DrawY >= LP_Y0) && (DrawY < LP_Y1);
  assign w_x_off   = DrawX - LP_X0;
  assign w_cell_x  = 4'(w_x_off >> CELL_LOG2);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_play_area  <= 1'b0;
      r_block_type <= EMPTY;
    end else begin
      r_play_area  <= w_in_area;
      r_block_type <= w_in_area ? block_color'(w_front_dat) : EMPTY;
    end
  end

  scan_row_buffer #(
    .COLS (BOARD_COLS)
  ) u_row_buf (
    .i_clk    (Clk),
    .i_rst_n  (Reset_n),
    .i_wr_en  (w_wr_en),
    .i_wr_idx (r_rd_col),
    .i_wr_dat (rd_data),
    .i_swap   (w_swap),
    .i_rd_idx (w_cell_x),
    .o_rd_dat (w_front_dat)
  );

  assign rd_req     = r_rd_req;
  assign rd_row     = r_rd_row;
  assign rd_col     = r_rd_col;
  assign underrun   = r_underrun;
  assign play_area  = r_play_area;
  assign block_type = r_block_type;
endmodule

// File: tb/tb_playfield_scanner.sv
// Bench for playfield_scanner: raster segments driven directly, outputs compared every cycle
// against a pixel/row-level model, plus pixel and trigger vector tables and hand sequences.
module tb_playfield_scanner;
  import playfield_scanner_pkg::*;

  localparam int AK_ALWAYS = 0;
  localparam int AK_RANDOM = 1;
  localparam int AK_NEVER  = 2;
  localparam int AK_STALL  = 3;

  typedef struct {
    int         x;
    int         y;
    logic       pa;
    logic [2:0] bt;
  } pix_vec_t;

  typedef struct {
    int   x;
    int   y;
    logic req;
    int   row;
  } trig_vec_t;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic [9:0] DrawX, DrawY;
  logic       rd_req, rd_ack;
  logic [4:0] rd_row;
  logic [3:0] rd_col;
  logic [2:0] rd_data;
  logic       play_area, underrun;
  logic [2:0] block_type;

  playfield_scanner dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col), .rd_ack(rd_ack), .rd_data(rd_data),
    .play_area(play_area), .block_type(block_type), .underrun(underrun)
  );

  initial forever #5 Clk = ~Clk;

  logic [2:0] board [20][10];
  logic [2:0] m_front [10];
  logic [2:0] m_q [$];
  bit         m_busy, m_underrun, m_pa;
  logic [2:0] m_bt;
  int         m_row;
  int         ack_mode, stall_left, dut_acks;
  int         n_checks, n_fail;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (DrawX=%0d DrawY=%0d t=%0t)", name, act, exp, DrawX, DrawY, $time);
    end
  endtask

  function automatic bit in_board(int x, int y);
    return (x >= 240) && (x < 240 + 10 * 16) && (y >= 80) && (y < 80 + 20 * 16);
  endfunction

  // Reference behaviour for one clock edge, from the pixel/row rules.
  task automatic model_edge();
    int x, y, ny;
    x = int'(DrawX);
    y = int'(DrawY);
    m_pa = in_board(x, y);
    m_bt = 3'd0;
    if (m_pa) m_bt = m_front[(x - 240) / 16];
    if (m_busy) begin
      if (x == 799) begin
        if (m_q.size() == 10) begin
          for (int i = 0; i < 10; i++) m_front[i] = m_q[i];
        end else begin
          m_underrun = 1'b1;
        end
        m_busy = 1'b0;
        m_q.delete();
      end else if (rd_ack && m_q.size() < 10) begin
        m_q.push_back(rd_data);
      end
    end else begin
      ny = (y + 1) % 525;
      if (x == 640 && ny >= 80 && ny < 400 && (ny - 80) % 16 == 0) begin
        m_busy = 1'b1;
        m_row  = (ny - 80) / 16;
      end
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_q.delete();
    m_underrun = 1'b0;
    m_pa = 1'b0;
    m_bt = 3'd0;
    m_row = 0;
    for (int i = 0; i < 10; i++) m_front[i] = 3'd0;
  endtask

  task automatic check_outputs();
    bit req;
    req = m_busy && (m_q.size() < 10);
    chk("play_area", 32'(play_area), 32'(m_pa));
    chk("block_type", 32'(block_type), 32'(m_bt));
    chk("underrun", 32'(underrun), 32'(m_underrun));
    chk("rd_req", 32'(rd_req), 32'(req));
    if (req) begin
      chk("rd_row", 32'(rd_row), m_row);
      chk("rd_col", 32'(rd_col), m_q.size());
    end
  endtask

  task automatic drive_ack();
    bit want;
    want = m_busy && (m_q.size() < 10);
    rd_data = 3'($urandom);
    case (ack_mode)
      AK_ALWAYS: rd_ack = 1'b1;
      AK_NEVER:  rd_ack = 1'b0;
      AK_STALL: begin
        if (want && m_q.size() == 4 && stall_left > 0) begin
          rd_ack = 1'b0;
          stall_left--;
        end else begin
          rd_ack = 1'b1;
        end
      end
      default: rd_ack = 1'($urandom_range(0, 1));
    endcase
    if (want && rd_ack) rd_data = board[m_row][m_q.size()];
    else if (want) rd_data = board[m_row][m_q.size()] ^ 3'($urandom_range(1, 7));
  endtask

  task automatic pix(int x, int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    drive_ack();
    if (rd_req === 1'b1 && rd_ack) dut_acks++;
    @(posedge Clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run_line(int y, int x0, int x1);
    for (int x = x0; x <= x1; x++) pix(x, y);
  endtask

  task automatic do_reset();
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_rd_req", 32'(rd_req), 0);
    chk("rst_rd_row", 32'(rd_row), 0);
    chk("rst_rd_col", 32'(rd_col), 0);
    chk("rst_play_area", 32'(play_area), 0);
    chk("rst_block_type", 32'(block_type), 32'(EMPTY));
    chk("rst_underrun", 32'(underrun), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete by t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    pix_vec_t  pv [11];
    trig_vec_t tv [10];
    int        y;

    pv[0]  = '{240, 80, 1'b1, CYAN};
    pv[1]  = '{256, 80, 1'b1, BLUE};
    pv[2]  = '{239, 80, 1'b0, EMPTY};
    pv[3]  = '{255, 80, 1'b1, CYAN};
    pv[4]  = '{399, 80, 1'b1, ORANGE};
    pv[5]  = '{400, 80, 1'b0, EMPTY};
    pv[6]  = '{300, 90, 1'b1, YELLOW};
    pv[7]  = '{240, 79, 1'b0, EMPTY};
    pv[8]  = '{340, 399, 1'b1, MAGENTA};
    pv[9]  = '{340, 400, 1'b0, EMPTY};
    pv[10] = '{330, 85, 1'b1, RED};

    tv[0] = '{640, 524, 1'b0, 0};
    tv[1] = '{640, 79,  1'b1, 0};
    tv[2] = '{640, 95,  1'b1, 1};
    tv[3] = '{640, 399, 1'b0, 0};
    tv[4] = '{640, 383, 1'b1, 19};
    tv[5] = '{640, 80,  1'b0, 0};
    tv[6] = '{639, 79,  1'b0, 0};
    tv[7] = '{641, 95,  1'b0, 0};
    tv[8] = '{640, 398, 1'b0, 0};
    tv[9] = '{640, 78,  1'b0, 0};

    n_checks = 0;
    n_fail = 0;
    ack_mode = AK_ALWAYS;
    stall_left = 0;
    dut_acks = 0;
    DrawX = 10'd0;
    DrawY = 10'd0;
    rd_ack = 1'b0;
    rd_data = 3'd0;
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) board[r][c] = 3'($urandom_range(0, 7));
    board[0][0] = CYAN;    board[0][1] = BLUE;  board[0][2] = ORANGE; board[0][3] = YELLOW;
    board[0][4] = GREEN;   board[0][5] = RED;   board[0][6] = MAGENTA; board[0][7] = CYAN;
    board[0][8] = BLUE;    board[0][9] = ORANGE;
    model_reset();
    do_reset();

    // row 0 fetch on line 79 with an ack every cycle
    run_line(79, 630, 640);
    chk("t1_req", 32'(rd_req), 1);
    chk("t1_row", 32'(rd_row), 0);
    chk("t1_col", 32'(rd_col), 0);
    dut_acks = 0;
    run_line(79, 641, 799);
    chk("t1_acks", dut_acks, 10);

    for (int i = 0; i < 11; i++) begin
      pix(pv[i].x, pv[i].y);
      chk($sformatf("pix%0d_pa", i), 32'(play_area), 32'(pv[i].pa));
      chk($sformatf("pix%0d_bt", i), 32'(block_type), 32'(pv[i].bt));
    end
    run_line(80, 230, 410);

    // stall three cycles on column 4 with garbage data on the bus
    ack_mode = AK_STALL;
    stall_left = 3;
    run_line(95, 630, 644);
    for (int k = 0; k < 3; k++) begin
      pix(645 + k, 95);
      chk("stall_req", 32'(rd_req), 1);
      chk("stall_row", 32'(rd_row), 1);
      chk("stall_col", 32'(rd_col), 4);
    end
    run_line(95, 648, 799);
    run_line(96, 230, 410);
    pix(240 + 4 * 16, 96);
    chk("stall_cell4", 32'(block_type), 32'(board[1][4]));

    // withhold every ack: deadline missed, front keeps row 1
    ack_mode = AK_NEVER;
    run_line(111, 630, 799);
    chk("underrun_set", 32'(underrun), 1);
    run_line(112, 230, 410);
    pix(240 + 4 * 16, 112);
    chk("no_swap_cell4", 32'(block_type), 32'(board[1][4]));

    // reset in the middle of a fetch at column 6
    ack_mode = AK_ALWAYS;
    run_line(127, 630, 646);
    chk("pre_rst_col", 32'(rd_col), 6);
    do_reset();
    run_line(128, 230, 410);
    pix(240, 128);
    chk("post_rst_empty", 32'(block_type), 32'(EMPTY));
    ack_mode = AK_RANDOM;
    run_line(143, 630, 640);
    chk("refetch_col", 32'(rd_col), 0);
    chk("refetch_row", 32'(rd_row), 4);
    run_line(143, 641, 799);
    run_line(144, 230, 410);

    for (int r = 5; r < 20; r++) begin
      y = 79 + 16 * r;
      run_line(y, 630, 799);
      run_line(y + 1 + int'($urandom_range(0, 14)), 230, 410);
    end

    // frame wrap and the line below the board never trigger
    ack_mode = AK_ALWAYS;
    run_line(524, 630, 640);
    chk("wrap_no_req", 32'(rd_req), 0);
    run_line(524, 641, 799);
    run_line(399, 630, 640);
    chk("row20_no_req", 32'(rd_req), 0);
    run_line(399, 641, 799);

    ack_mode = AK_NEVER;
    for (int i = 0; i < 10; i++) begin
      do_reset();
      pix(tv[i].x, tv[i].y);
      chk($sformatf("trig%0d_req", i), 32'(rd_req), 32'(tv[i].req));
      if (tv[i].req) begin
        chk($sformatf("trig%0d_row", i), 32'(rd_row), tv[i].row);
        chk($sformatf("trig%0d_col", i), 32'(rd_col), 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
